// File: rtl/evg_heartbeat_generator.sv
// Heartbeat and sequence-start timing source for the event generator, evgTxClk domain.
// Strobes are registered one clock after counter expiry or a marker edge; there is no backpressure.
module evg_heartbeat_generator #(
  parameter int INTERVAL_WIDTH    = 32,
  parameter int SEQ_DIVIDER_WIDTH = 8,
  parameter int COUNT_WIDTH       = 16
) (
  input  logic                         evgTxClk,
  input  logic                         evgTxRst,
  input  logic                         enable,
  input  logic                         resyncEnable,
  input  logic [INTERVAL_WIDTH-1:0]    hbInterval,
  input  logic [1:0]                   seqMode,
  input  logic [SEQ_DIVIDER_WIDTH-1:0] seqDivider,
  input  logic                         seqArm,
  input  logic                         externalSync_a,
  output logic                         evgHeartbeatRequest,
  output logic                         evgSequenceStart,
  output logic                         armed,
  output logic                         synced,
  output logic [COUNT_WIDTH-1:0]       heartbeatCount,
  output logic [COUNT_WIDTH-1:0]       misalignCount,
  output logic [INTERVAL_WIDTH-1:0]    lastSyncOffset
);

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_SYNC = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  localparam logic [1:0] MODE_OFF      = 2'd0;
  localparam logic [1:0] MODE_PERIODIC = 2'd1;
  localparam logic [1:0] MODE_SINGLE   = 2'd2;

  state_t                         state_q, state_d;
  logic                           sync_meta_q, sync_q, sync_prev_q, mark_edge_q;
  logic [INTERVAL_WIDTH-1:0]      cnt_q, cnt_d, reload;
  logic [INTERVAL_WIDTH-1:0]      offset_q, offset_d;
  logic [SEQ_DIVIDER_WIDTH-1:0]   div_q, div_d;
  logic [1:0]                     mode_q, mode_eff;
  logic                           hb_q, hb_d, seq_q, seq_d;
  logic                           armed_q, armed_d, synced_q, synced_d;
  logic [COUNT_WIDTH-1:0]         hb_cnt_q, hb_cnt_d, mis_cnt_q, mis_cnt_d;
  logic                           expiry;

  // Reserved mode 3 behaves as off; an interval of 0 would never let the strobe drop.
  assign mode_eff = (seqMode == 2'd3) ? MODE_OFF : seqMode;
  assign reload   = (hbInterval == '0) ? INTERVAL_WIDTH'(1) : hbInterval;

  // Two-flop synchronizer followed by a registered rising-edge detect.
  always_ff @(posedge evgTxClk or posedge evgTxRst) begin
    if (evgTxRst) begin
      sync_meta_q <= 1'b0;
      sync_q      <= 1'b0;
      sync_prev_q <= 1'b0;
      mark_edge_q <= 1'b0;
    end else begin
      sync_meta_q <= externalSync_a;
      sync_q      <= sync_meta_q;
      sync_prev_q <= sync_q;
      mark_edge_q <= sync_q & ~sync_prev_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hb_d      = 1'b0;
    offset_d  = offset_q;
    synced_d  = synced_q;
    mis_cnt_d = mis_cnt_q;
    expiry    = (cnt_q == '0);
    unique case (state_q)
      ST_IDLE: begin
        cnt_d = '0;
        if (enable) begin
          if (resyncEnable) begin
            state_d = ST_WAIT_SYNC;
          end else begin
            state_d = ST_RUN;
            cnt_d   = reload;
          end
        end
      end
      ST_WAIT_SYNC: begin
        if (mark_edge_q) begin
          hb_d     = 1'b1;
          cnt_d    = reload;
          offset_d = '0;
          synced_d = 1'b1;
          state_d  = ST_RUN;
        end
      end
      ST_RUN: begin
        hb_d  = expiry;
        cnt_d = expiry ? reload : cnt_q - INTERVAL_WIDTH'(1);
        // A marker on the expiry cycle merges with the natural heartbeat.
        if (resyncEnable && mark_edge_q) begin
          hb_d     = 1'b1;
          cnt_d    = reload;
          offset_d = cnt_q;
          synced_d = 1'b1;
          if (!expiry && (mis_cnt_q != '1)) begin
            mis_cnt_d = mis_cnt_q + COUNT_WIDTH'(1);
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
    if (!enable) begin
      state_d  = ST_IDLE;
      cnt_d    = '0;
      hb_d     = 1'b0;
      synced_d = 1'b0;
    end
  end

  always_comb begin
    seq_d    = 1'b0;
    div_d    = div_q;
    armed_d  = armed_q;
    hb_cnt_d = hb_cnt_q;
    if (hb_d) begin
      hb_cnt_d = hb_cnt_q + COUNT_WIDTH'(1);
      if (mode_eff == MODE_PERIODIC) begin
        seq_d = (div_q == seqDivider);
        div_d = seq_d ? '0 : div_q + SEQ_DIVIDER_WIDTH'(1);
      end else if (mode_eff == MODE_SINGLE) begin
        seq_d   = armed_q;
        armed_d = 1'b0;
      end
    end
    // An arm on the heartbeat cycle survives the clear and waits for the next one.
    if (seqArm && (mode_eff == MODE_SINGLE)) begin
      armed_d = 1'b1;
    end
    if (!enable || (mode_eff != MODE_SINGLE)) begin
      armed_d = 1'b0;
    end
    if (!enable || (mode_eff != mode_q)) begin
      div_d = '0;
    end
  end

  always_ff @(posedge evgTxClk or posedge evgTxRst) begin
    if (evgTxRst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      div_q     <= '0;
      mode_q    <= MODE_OFF;
      hb_q      <= 1'b0;
      seq_q     <= 1'b0;
      armed_q   <= 1'b0;
      synced_q  <= 1'b0;
      hb_cnt_q  <= '0;
      mis_cnt_q <= '0;
      offset_q  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      div_q     <= div_d;
      mode_q    <= mode_eff;
      hb_q      <= hb_d;
      seq_q     <= seq_d;
      armed_q   <= armed_d;
      synced_q  <= synced_d;
      hb_cnt_q  <= hb_cnt_d;
      mis_cnt_q <= mis_cnt_d;
      offset_q  <= offset_d;
    end
  end

  assign evgHeartbeatRequest = hb_q;
  assign evgSequenceStart    = seq_q;
  assign armed               = armed_q;
  assign synced              = synced_q;
  assign heartbeatCount      = hb_cnt_q;
  assign misalignCount       = mis_cnt_q;
  assign lastSyncOffset      = offset_q;

endmodule

// File: tb/tb_evg_heartbeat_generator.sv
// Bench for evg_heartbeat_generator: directed steps plus random stimulus against a timeline model.
module tb_evg_heartbeat_generator;
  localparam int IW = 32;
  localparam int SW = 8;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst, en, rs, arm, ext;
  logic [IW-1:0] iv;
  logic [1:0]    mode;
  logic [SW-1:0] sdiv;
  logic          hb_o, seq_o, armed_o, synced_o;
  logic [CW-1:0] hbcnt_o, mis_o;
  logic [IW-1:0] off_o;

  evg_heartbeat_generator #(
    .INTERVAL_WIDTH(IW), .SEQ_DIVIDER_WIDTH(SW), .COUNT_WIDTH(CW)
  ) dut (
    .evgTxClk(clk), .evgTxRst(rst), .enable(en), .resyncEnable(rs),
    .hbInterval(iv), .seqMode(mode), .seqDivider(sdiv), .seqArm(arm),
    .externalSync_a(ext), .evgHeartbeatRequest(hb_o), .evgSequenceStart(seq_o),
    .armed(armed_o), .synced(synced_o), .heartbeatCount(hbcnt_o),
    .misalignCount(mis_o), .lastSyncOffset(off_o)
  );

  always #5 clk = ~clk;

  int            n_asrt, n_fail, cyc;
  string         phase;
  int            mark_q[$];
  bit            m_run, m_wait, m_hb, m_seq, m_armed, m_synced;
  int            m_next_hb, m_div;
  logic [1:0]    m_prev_mode;
  logic [CW-1:0] m_hbcnt, m_mis;
  logic [IW-1:0] m_off;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_asrt++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_wait = 0; m_hb = 0; m_seq = 0; m_armed = 0; m_synced = 0;
    m_next_hb = 0; m_div = 0; m_prev_mode = 2'd0;
    m_hbcnt = '0; m_mis = '0; m_off = '0;
    mark_q.delete();
  endtask

  // Timeline model: heartbeats scheduled by absolute edge number.
  task automatic model_edge();
    bit         mk;
    int         e;
    logic [1:0] me;
    while (mark_q.size() > 0 && mark_q[0] < cyc) void'(mark_q.pop_front());
    mk = 0;
    if (mark_q.size() > 0 && mark_q[0] == cyc) begin
      mk = 1;
      void'(mark_q.pop_front());
    end
    e  = (iv == 0) ? 1 : int'(iv);
    me = (mode == 2'd3) ? 2'd0 : mode;
    m_hb = 0; m_seq = 0;
    if (!en) begin
      m_run = 0; m_wait = 0; m_synced = 0;
    end else if (!m_run && !m_wait) begin
      if (rs) m_wait = 1;
      else begin m_run = 1; m_next_hb = cyc + e + 1; end
    end else if (m_wait) begin
      if (mk) begin
        m_hb = 1; m_wait = 0; m_run = 1; m_next_hb = cyc + e + 1; m_off = '0; m_synced = 1;
      end
    end else if (rs && mk) begin
      m_off = IW'(m_next_hb - cyc);
      if (cyc != m_next_hb && m_mis != '1) m_mis++;
      m_hb = 1; m_synced = 1; m_next_hb = cyc + e + 1;
    end else if (cyc == m_next_hb) begin
      m_hb = 1; m_next_hb = cyc + e + 1;
    end
    if (m_hb) begin
      m_hbcnt++;
      if (me == 2'd1) begin
        if (m_div == int'(sdiv)) begin m_seq = 1; m_div = 0; end
        else m_div++;
      end else if (me == 2'd2) begin
        m_seq = m_armed; m_armed = 0;
      end
    end
    if (en && me == 2'd2 && arm) m_armed = 1;
    if (!en || me != 2'd2) m_armed = 0;
    if (!en || me != m_prev_mode) m_div = 0;
    m_prev_mode = me;
  endtask

  task automatic check_all(input string p);
    check({p, ":hb"},        hb_o,     m_hb);
    check({p, ":seq"},       seq_o,    m_seq);
    check({p, ":armed"},     armed_o,  m_armed);
    check({p, ":synced"},    synced_o, m_synced);
    check({p, ":hbcnt"},     hbcnt_o,  m_hbcnt);
    check({p, ":miscnt"},    mis_o,    m_mis);
    check({p, ":offset"},    off_o,    m_off);
    check({p, ":seq_alone"}, seq_o & ~hb_o, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check_all(phase);
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic set_marker(input logic v);
    if (v && !ext) mark_q.push_back(cyc + 4);
    ext = v;
  endtask

  task automatic wait_hb(input string tag);
    int i = 0;
    do begin
      step();
      i++;
    end while (!hb_o && i < 200);
    check(tag, hb_o, 1'b1);
  endtask

  initial begin
    int            nseq;
    logic [CW-1:0] base;
    n_asrt = 0; n_fail = 0; cyc = 0;
    rst = 1; en = 0; rs = 0; arm = 0; ext = 0; iv = 9; mode = 2'd0; sdiv = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst = 0;

    phase = "freerun";
    en = 1;
    steps(51);
    check("freerun_count_50clk", hbcnt_o, 16'd5);

    phase = "disable";
    base = m_hbcnt;
    en = 0;
    steps(3);
    check("disable_hold_count", hbcnt_o, base);

    phase = "periodic_iv0";
    mode = 2'd1; sdiv = 8'd3; iv = 0;
    step();
    base = m_hbcnt; nseq = 0;
    en = 1;
    for (int i = 0; i < 25; i++) begin
      step();
      if (seq_o) nseq++;
    end
    check("periodic_hb_count", 16'(hbcnt_o - base), 16'd12);
    check("periodic_seq_count", nseq, 3);

    phase = "periodic_rand";
    for (int r = 0; r < 2; r++) begin
      en = 0; step();
      iv = $urandom_range(0, 6); sdiv = $urandom_range(0, 4); step();
      en = 1; steps(60);
    end

    phase = "single";
    en = 0; mode = 2'd2; iv = 4; step();
    en = 1; step();
    arm = 1; step(); arm = 0;
    check("single_armed_set", armed_o, 1'b1);
    wait_hb("single_first_hb");
    check("single_seq_on_hb", seq_o, 1'b1);
    check("single_armed_clear", armed_o, 1'b0);
    wait_hb("single_second_hb");
    check("single_no_second_seq", seq_o, 1'b0);
    phase = "single_rand";
    for (int i = 0; i < 80; i++) begin
      arm = ($urandom_range(0, 5) == 0);
      step();
    end
    arm = 0;

    phase = "resync";
    en = 0; mode = 2'd0; rs = 1; iv = 99; steps(2);
    en = 1; steps(5);
    set_marker(1);
    steps(3);
    check("ws_no_early_hb", hb_o, 1'b0);
    step();
    check("ws_hb_4clk", hb_o, 1'b1);
    check("ws_synced", synced_o, 1'b1);
    set_marker(0);
    while (cyc < m_next_hb - 7) step();
    set_marker(1);
    steps(4);
    check("early_hb", hb_o, 1'b1);
    check("early_offset", off_o, 32'd3);
    check("early_miscnt", mis_o, 16'd1);
    set_marker(0);
    while (cyc < m_next_hb - 4) step();
    set_marker(1);
    steps(4);
    check("aligned_hb", hb_o, 1'b1);
    check("aligned_miscnt", mis_o, 16'd1);
    check("aligned_offset", off_o, 32'd0);
    step();
    check("aligned_single_hb", hb_o, 1'b0);
    set_marker(0);

    phase = "resync_rand";
    en = 0; step();
    iv = $urandom_range(15, 40); mode = 2'd1; sdiv = $urandom_range(0, 2); step();
    en = 1;
    for (int i = 0; i < 8; i++) begin
      steps($urandom_range(6, 60));
      set_marker(1);
      steps($urandom_range(2, 4));
      set_marker(0);
    end
    steps(10);

    phase = "disable_mid";
    base = m_hbcnt;
    en = 0;
    steps(6);
    check("dis_mid_count_held", hbcnt_o, base);
    check("dis_mid_synced_clear", synced_o, 1'b0);

    phase = "pre_reset";
    rs = 0; iv = 4; mode = 2'd1; sdiv = '0; step();
    en = 1;
    wait_hb("pre_reset_hb");
    rst = 1;
    #1;
    model_reset();
    check_all("async_reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    phase = "restart";
    steps(5);
    check("restart_no_hb_yet", hbcnt_o, 16'd0);
    step();
    check("restart_first_hb", hb_o, 1'b1);
    steps(20);

    $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
    $finish;
  end
endmodule

// File: doc/evg_heartbeat_generator.md
Name: evg_heartbeat_generator

Overview:
- Upstream timing source for the event generator.
- Produces the single-cycle evgHeartbeatRequest and evgSequenceStart strobes in the transmit clock domain.
- Heartbeats come from a programmable free-running interval counter. The counter can optionally be phase-locked to an external asynchronous marker, such as a 1 PPS or ring-revolution signal.
- Sequence starts are issued on selected heartbeats, either periodically or as a single armed shot.

Parameters:
INTERVAL_WIDTH, 32, width of heartbeat interval counter and offset capture
SEQ_DIVIDER_WIDTH, 8, width of periodic sequence-start divider
COUNT_WIDTH, 16, width of heartbeat and misalign status counters

Ports:
evgTxClk  in  1  transmit clock; all logic on rising edge
evgTxRst  in  1  asynchronous, active-high reset
enable  in  1  level; 0 halts generation
resyncEnable  in  1  level; 1 = lock heartbeat phase to externalSync_a
hbInterval  in  INTERVAL_WIDTH  heartbeat period minus 1, in clocks; quasi-static
seqMode  in  2  0 off, 1 periodic, 2 single-shot, 3 reserved (treated as 0)
seqDivider  in  SEQ_DIVIDER_WIDTH  periodic mode: sequence start every seqDivider+1 heartbeats
seqArm  in  1  single-cycle pulse; arms single-shot
externalSync_a  in  1  asynchronous phase marker
evgHeartbeatRequest  out  1  registered single-cycle heartbeat strobe
evgSequenceStart  out  1  registered single-cycle strobe, only ever coincident with evgHeartbeatRequest
armed  out  1  single-shot pending
synced  out  1  at least one marker accepted since entering RUN with resync
heartbeatCount  out  COUNT_WIDTH  heartbeats issued, wraps
misalignCount  out  COUNT_WIDTH  markers arriving off natural expiry, saturates at all-ones
lastSyncOffset  out  INTERVAL_WIDTH  interval counter value when the last marker was detected

Behaviour:
- Reset: all outputs 0, state IDLE, interval counter 0, divider counter 0.
- Marker input:
  - externalSync_a passes through a 2-flop synchronizer, then a rising-edge detect flop.
  - markEdge asserts on the 3rd evgTxClk edge after externalSync_a goes high.
  - Strobes are registered, so a marker-driven heartbeat appears 1 clock after markEdge.
- Effective period: max(hbInterval,1)+1 clocks. hbInterval=0 is treated as 1.
- States:
  - IDLE: enable=1 and resyncEnable=0 -> RUN, counter loaded with effective interval, first heartbeat at natural expiry. enable=1 and resyncEnable=1 -> WAIT_SYNC.
  - WAIT_SYNC: no heartbeats. markEdge -> heartbeat strobe, counter loaded, lastSyncOffset=0, synced=1, -> RUN.
  - RUN:
    - Counter decrements each clock. At 0 it fires a heartbeat and reloads.
    - With resyncEnable=1 and markEdge, lastSyncOffset captures the counter value.
    - If the counter is 0 that cycle: the single natural heartbeat fires.
    - Otherwise: a heartbeat fires immediately, the counter reloads, and misalignCount increments.
    - synced=1 after any accepted marker.
  - Any state: enable=0 -> IDLE next clock. synced, armed and the divider counter clear. Status counters hold.
- Coincident marker and expiry never yield two heartbeats.
- Sequence start, evaluated on each heartbeat:
  - mode 1: divider counter increments per heartbeat. At seqDivider it wraps to 0 and asserts evgSequenceStart with that heartbeat.
  - mode 2: seqArm sets armed. The next heartbeat asserts evgSequenceStart and clears armed. seqArm arriving on the same clock as a heartbeat arms for the following heartbeat.
  - Mode change clears the divider counter.
- heartbeatCount increments on every heartbeat and wraps.
- Reset asserted mid-operation: outputs 0 asynchronously, including any strobe in flight.

Test Plan:
- Free-run: reset, enable=1, resyncEnable=0, hbInterval=9 -> heartbeat every 10 clocks; heartbeatCount=5 after 50 clocks.
- Periodic: seqMode=1, seqDivider=3 -> evgSequenceStart on heartbeats 4, 8, 12, always coincident with a heartbeat. hbInterval=0 -> period 2.
- Single-shot: seqMode=2, seqArm pulse -> armed=1; next heartbeat carries evgSequenceStart and armed=0. A second heartbeat carries none.
- Resync:
  - Marker in WAIT_SYNC -> first heartbeat 4 clocks after marker rise, synced=1.
  - Marker 3 clocks early in RUN with hbInterval=99 -> immediate heartbeat, lastSyncOffset=3, misalignCount=1.
  - Marker aligned to expiry -> single heartbeat, misalignCount unchanged.
- Disable and reset mid-run: enable=0 -> no strobes, state IDLE, counters held. evgTxRst asserted during a strobe -> outputs 0 immediately; after release the block restarts from IDLE.
